// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-side signals shared by the IF/LS port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BW = $clog2(DATA_WIDTH / 8) + 1;

  logic                  if_req_valid;
  logic [ADDR_WIDTH-1:0] if_req_addr;
  logic                  if_req_ready;
  logic                  if_rsp_valid;
  logic [DATA_WIDTH-1:0] if_rsp_data;
  logic                  if_rsp_err;

  logic                  ls_req_valid;
  logic                  ls_req_write;
  logic [ADDR_WIDTH-1:0] ls_req_addr;
  logic [DATA_WIDTH-1:0] ls_req_wdata;
  logic [BW-1:0]         ls_req_bytes;
  logic                  ls_req_ready;
  logic                  ls_rsp_valid;
  logic [DATA_WIDTH-1:0] ls_rsp_rdata;
  logic                  ls_rsp_err;

  logic                  mem_valid;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BW-1:0]         mem_bytes;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_done;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  ls_req_valid, ls_req_write, ls_req_addr, ls_req_wdata, ls_req_bytes,
    output ls_req_ready, ls_rsp_valid, ls_rsp_rdata, ls_rsp_err,
    output mem_valid, mem_write, mem_addr, mem_wdata, mem_bytes,
    input  mem_rdata, mem_done
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output ls_req_valid, ls_req_write, ls_req_addr, ls_req_wdata, ls_req_bytes,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata, ls_rsp_err,
    input  mem_valid, mem_write, mem_addr, mem_wdata, mem_bytes,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// one transaction outstanding, with a BUSY-state watchdog.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int BW         = $clog2(DATA_BYTES) + 1;
  localparam int CW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {SRC_IF, SRC_LS} src_t;

  state_t                state;
  src_t                  last_grant;
  src_t                  owner;
  logic [CW-1:0]         cnt;

  logic                  mem_valid_q;
  logic                  mem_write_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [BW-1:0]         mem_bytes_q;

  logic                  if_rsp_valid_q, if_rsp_err_q;
  logic [DATA_WIDTH-1:0] if_rsp_data_q;
  logic                  ls_rsp_valid_q, ls_rsp_err_q;
  logic [DATA_WIDTH-1:0] ls_rsp_rdata_q;

  logic                  grant_if, grant_ls, bytes_bad, finish;
  logic [DATA_WIDTH-1:0] done_data;

  // Ready is only offered from IDLE; on a tie the requester not granted last time wins.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state == IDLE && !rst) begin
      if (bus.if_req_valid && bus.ls_req_valid) begin
        grant_if = (last_grant == SRC_LS);
        grant_ls = (last_grant == SRC_IF);
      end else begin
        grant_if = bus.if_req_valid;
        grant_ls = bus.ls_req_valid;
      end
    end
  end

  assign bytes_bad = (bus.ls_req_bytes == '0) || (bus.ls_req_bytes > BW'(DATA_BYTES));
  assign finish    = bus.mem_done || (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign done_data = (bus.mem_done && !mem_write_q) ? bus.mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= SRC_LS;
      owner          <= SRC_IF;
      cnt            <= '0;
      mem_valid_q    <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_bytes_q    <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_err_q   <= 1'b0;
      if_rsp_data_q  <= '0;
      ls_rsp_valid_q <= 1'b0;
      ls_rsp_err_q   <= 1'b0;
      ls_rsp_rdata_q <= '0;
    end else begin
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            owner       <= SRC_IF;
            last_grant  <= SRC_IF;
            mem_write_q <= 1'b0;
            mem_addr_q  <= bus.if_req_addr;
            mem_wdata_q <= '0;
            mem_bytes_q <= BW'(DATA_BYTES);
            cnt         <= '0;
            mem_valid_q <= 1'b1;
            state       <= BUSY;
          end else if (grant_ls) begin
            owner       <= SRC_LS;
            last_grant  <= SRC_LS;
            mem_write_q <= bus.ls_req_write;
            mem_addr_q  <= bus.ls_req_addr;
            mem_wdata_q <= bus.ls_req_wdata;
            mem_bytes_q <= bus.ls_req_write ? bus.ls_req_bytes : BW'(DATA_BYTES);
            cnt         <= '0;
            // Illegal byte counts skip the memory and complete with an error.
            if (bytes_bad) begin
              ls_rsp_valid_q <= 1'b1;
              ls_rsp_rdata_q <= '0;
              ls_rsp_err_q   <= 1'b1;
              state          <= RESP;
            end else begin
              mem_valid_q <= 1'b1;
              state       <= BUSY;
            end
          end
        end
        BUSY: begin
          if (finish) begin
            mem_valid_q <= 1'b0;
            state       <= RESP;
            if (owner == SRC_IF) begin
              if_rsp_valid_q <= 1'b1;
              if_rsp_data_q  <= done_data;
              if_rsp_err_q   <= !bus.mem_done;
            end else begin
              ls_rsp_valid_q <= 1'b1;
              ls_rsp_rdata_q <= done_data;
              ls_rsp_err_q   <= !bus.mem_done;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_req_ready = grant_if;
  assign bus.ls_req_ready = grant_ls;
  assign bus.if_rsp_valid = if_rsp_valid_q;
  assign bus.if_rsp_data  = if_rsp_data_q;
  assign bus.if_rsp_err   = if_rsp_err_q;
  assign bus.ls_rsp_valid = ls_rsp_valid_q;
  assign bus.ls_rsp_rdata = ls_rsp_rdata_q;
  assign bus.ls_rsp_err   = ls_rsp_err_q;
  assign bus.mem_valid    = mem_valid_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_bytes    = mem_bytes_q;
endmodule
